interrupt_unit: RTL and testbench
=================================

// Module: interrupt_unit
// PURPOSE
//  Front end for the multicycle controller's interrupt path. Synchronises and edge-detects
//  NUM_IRQ maskable lines and one NMI line, holds them pending until the controller acknowledges
//  in preFetch, and produces INT/NMI/INTD plus the handler vector and saved PC (EPC).
//  Tracks service nesting: an NMI may preempt an INT handler; nothing preempts an NMI.
// PARAMETERS
//  NUM_IRQ   4             number of maskable IRQ lines (1..8); line 0 = highest priority
//  AW        32            width of PC / vector / EPC
//  VEC_NMI   32'h0000_0040 NMI handler address
//  VEC_INT   32'h0000_0080 INT vector base; vector = VEC_INT + 8*id
// PORTS
//  Clk      in  1       clock, rising edge
//  Rst_n    in  1       asynchronous active-low reset
//  Irq      in  NUM_IRQ raw maskable requests, asynchronous, rising-edge sensitive
//  NmiIn    in  1       raw NMI request, asynchronous, rising-edge sensitive
//  MaskWe   in  1       write enable for mask register
//  MaskIn   in  NUM_IRQ new mask (1 = enabled)
//  IntAck   in  1       one-cycle pulse: controller has taken an interrupt (isInterrupted)
//  AckIna   in  1       with IntAck: 1 = INT taken, 0 = NMI taken (controller INA)
//  Eret     in  1       one-cycle pulse: handler return
//  PcIn     in  AW      current PC, captured into EPC on IntAck
//  INT      out 1       |(pending & mask)
//  NMI      out 1       NMI pending
//  INTD     out 1       interrupts disabled (any handler active)
//  Vector   out AW      handler address of most recent accepted ack
//  Epc      out AW      return address of the active handler
//  IrqId    out 3       id of most recently accepted INT
// BEHAVIOUR
//  Reset: sync/prev flops, pending, nmi_pend, mask = 0; state IDLE; INT=NMI=INTD=0;
//   Vector=VEC_NMI; Epc=0; IrqId=0. Async assert, output effect immediate.
//  Input path: 2-flop sync + prev flop per line; edge = sync2 & ~prev. Pending bit sets on the
//   3rd rising Clk edge after the raw rise; INT/NMI are combinational from registers.
//  Line high when Rst_n releases registers as an edge (sync flops reset to 0).
//  State machine (INTD = state != IDLE):
//   IDLE       -IntAck&AckIna&INT-> INT_SVC;  -IntAck&~AckIna&NMI-> NMI_SVC
//   INT_SVC    -IntAck&~AckIna&NMI-> NMI_NEST; -Eret-> IDLE
//   NMI_SVC    -Eret-> IDLE
//   NMI_NEST   -Eret-> INT_SVC (Epc restored from saved EPC of INT)
//  Accepted INT ack: id = lowest index of pending&mask (old mask if MaskWe same cycle);
//   clear pending[id]; IrqId=id; Vector=VEC_INT+8*id; epc0<=PcIn.
//  Accepted NMI ack: clear nmi_pend; Vector=VEC_NMI; IDLE: epc0<=PcIn; INT_SVC: epc1<=PcIn.
//  Epc = epc1 in NMI_NEST, else epc0.
//  Ignored acks (no state/pending change): INT ack with INT=0 or state!=IDLE; NMI ack with NMI=0
//   or state in {NMI_SVC,NMI_NEST}. Eret in IDLE ignored.
//  Simultaneous: new edge on a bit in the same cycle it is cleared by ack -> stays pending (set
//   wins). IntAck and Eret together -> Eret ignored. Masked lines still latch pending; INT rises
//   when mask later enables them. NMI pending during NMI_SVC stays pending until after Eret.
//  Widths: 8*id computed at AW bits, id zero-extended; no overflow check on VEC_INT.
// STRUCTURE
//  Shared package/include (ctrl_defs): state encodings IDLE/INT_SVC/NMI_SVC/NMI_NEST (2 bits),
//   VEC_NMI/VEC_INT defaults, AckIna encoding INA_INT=1/INA_NMI=0.
//  One sub-module: irq_edge_sync (2-flop sync + edge pulse, async active-low reset),
//   instantiated NUM_IRQ+1 times. Priority encoder and FSM inline.
// TESTING
//  Irq[2] rises, mask=4'b0100 -> INT=1 after 3rd edge; IntAck,AckIna=1,PcIn=0x100 ->
//   INTD=1, Vector=0x90, IrqId=2, Epc=0x100, INT=0; Eret -> INTD=0.
//  Irq[1],Irq[3] pending, mask=4'b1010 -> ack gives IrqId=1, Vector=0x88; INT stays 1 (bit 3).
//  In INT_SVC (Epc=0x100) NmiIn rises, NMI ack with PcIn=0x204 -> NMI_NEST, Epc=0x204,
//   Vector=0x40; Eret -> INT_SVC, Epc=0x100; Eret -> IDLE.
//  Irq[0] edge arriving in ack-clear cycle of bit 0 -> pending[0] stays 1, INT=1 after ack.
//  Irq[3] pending with mask=0 -> INT=0; MaskWe, MaskIn=4'b1000 -> INT=1 next cycle.
//  Rst_n low in NMI_NEST -> INTD=0, NMI=0, INT=0, Epc=0 immediately (before next Clk edge).

Source files
------------

// File: rtl/interrupt_unit_pkg.sv
// interrupt_unit_pkg: shared service-state encoding, vector defaults and INA encoding
package interrupt_unit_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, INT_SVC = 2'd1, NMI_SVC = 2'd2, NMI_NEST = 2'd3} svc_state_e;
    localparam logic [31:0] VEC_NMI_DEF = 32'h0000_0040;
    localparam logic [31:0] VEC_INT_DEF = 32'h0000_0080;
    localparam logic INA_INT = 1'b1;
    localparam logic INA_NMI = 1'b0;
endpackage

// File: rtl/interrupt_unit_edge_sync.sv
// irq_edge_sync: two-flop synchroniser with a one-cycle rising-edge pulse
module irq_edge_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic edge_o
);
    logic sync1_q, sync2_q, prev_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end
    assign edge_o = sync2_q & ~prev_q;
endmodule

// File: rtl/interrupt_unit.sv
// interrupt_unit: synchronised IRQ/NMI pending, priority select, nested service tracking,
// handler vector and saved-PC generation for the multicycle controller.
module interrupt_unit
    import interrupt_unit_pkg::*;
#(
    parameter int              NUM_IRQ = 4,
    parameter int              AW      = 32,
    parameter logic [AW-1:0]   VEC_NMI = AW'(VEC_NMI_DEF),
    parameter logic [AW-1:0]   VEC_INT = AW'(VEC_INT_DEF)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               nmi_in_i,
    input  logic               mask_we_i,
    input  logic [NUM_IRQ-1:0] mask_i,
    input  logic               int_ack_i,
    input  logic               ack_ina_i,
    input  logic               eret_i,
    input  logic [AW-1:0]      pc_i,
    output logic               int_o,
    output logic               nmi_o,
    output logic               intd_o,
    output logic [AW-1:0]      vector_o,
    output logic [AW-1:0]      epc_o,
    output logic [2:0]         irq_id_o
);
    svc_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] irq_edge, pend_q, pend_d, mask_q, active, clr;
    logic               nmi_edge, nmi_pend_q, int_take, nmi_take, eret_take;
    logic [2:0]         id, irq_id_q;
    logic [AW-1:0]      vector_q, epc0_q, epc1_q;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_edge_sync u_sync (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(irq_i[g]), .edge_o(irq_edge[g]));
    end
    irq_edge_sync u_nmi_sync (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(nmi_in_i), .edge_o(nmi_edge));

    assign active   = pend_q & mask_q;
    assign int_o    = |active;
    assign nmi_o    = nmi_pend_q;
    assign intd_o   = state_q != IDLE;
    assign vector_o = vector_q;
    assign irq_id_o = irq_id_q;
    assign epc_o    = (state_q == NMI_NEST) ? epc1_q : epc0_q;

    // Line 0 has the highest priority, so the lowest set index wins
    always_comb begin
        id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (active[i]) id = 3'(i);
    end

    assign int_take  = int_ack_i & (ack_ina_i == INA_INT) & int_o & (state_q == IDLE);
    assign nmi_take  = int_ack_i & (ack_ina_i == INA_NMI) & nmi_o & (state_q == IDLE || state_q == INT_SVC);
    assign eret_take = eret_i & ~int_ack_i & (state_q != IDLE);
    assign clr       = int_take ? (NUM_IRQ'(1) << id) : '0;
    // A fresh edge in the clearing cycle must not be lost, so set wins over clear
    assign pend_d    = (pend_q & ~clr) | irq_edge;

    always_comb begin
        state_d = state_q;
        if (int_take)
            state_d = INT_SVC;
        else if (nmi_take)
            state_d = (state_q == IDLE) ? NMI_SVC : NMI_NEST;
        else if (eret_take)
            state_d = (state_q == NMI_NEST) ? INT_SVC : IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q     <= '0;
            nmi_pend_q <= 1'b0;
            mask_q     <= '0;
            irq_id_q   <= '0;
            vector_q   <= VEC_NMI;
            epc0_q     <= '0;
            epc1_q     <= '0;
        end else begin
            pend_q     <= pend_d;
            nmi_pend_q <= (nmi_pend_q & ~nmi_take) | nmi_edge;
            if (mask_we_i) mask_q <= mask_i;
            if (int_take) begin
                irq_id_q <= id;
                vector_q <= VEC_INT + (AW'(id) << 3);
                epc0_q   <= pc_i;
            end
            if (nmi_take) begin
                vector_q <= VEC_NMI;
                if (state_q == IDLE) epc0_q <= pc_i;
                else                 epc1_q <= pc_i;
            end
        end
    end
endmodule

// File: tb/tb_interrupt_unit.sv
// tb_interrupt_unit: random + directed stimulus, reference model with a service stack,
// scoreboard queue drained by an independent output monitor.
module tb_interrupt_unit;
    logic        clk = 0, rst_n = 0, smp = 0;
    logic [3:0]  irq = 0, mask_in = 0;
    logic        nmi = 0, mask_we = 0, ack = 0, ina = 0, eret = 0;
    logic [31:0] pc = 0;
    logic        int_o, nmi_o, intd_o;
    logic [31:0] vector_o, epc_o;
    logic [2:0]  irq_id_o;

    interrupt_unit dut (
        .clk_i(clk), .rst_n_i(rst_n), .irq_i(irq), .nmi_in_i(nmi), .mask_we_i(mask_we),
        .mask_i(mask_in), .int_ack_i(ack), .ack_ina_i(ina), .eret_i(eret), .pc_i(pc),
        .int_o(int_o), .nmi_o(nmi_o), .intd_o(intd_o), .vector_o(vector_o), .epc_o(epc_o),
        .irq_id_o(irq_id_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        i;
        logic        n;
        logic        d;
        logic [31:0] v;
        logic [31:0] e;
        logic [2:0]  id;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0;

    // Reference model: rises become pending two edges after the edge that first samples them
    bit [3:0]    m_pend, m_mask, m_last, m_d1, m_d2;
    bit          m_np, m_nlast, m_nd1, m_nd2;
    bit          stk_nmi[$];
    logic [31:0] stk_epc[$];
    logic [31:0] m_base, m_vec;
    logic [2:0]  m_id;

    task automatic m_reset();
        m_pend = 0; m_mask = 0; m_last = 0; m_d1 = 0; m_d2 = 0;
        m_np = 0; m_nlast = 0; m_nd1 = 0; m_nd2 = 0;
        stk_nmi.delete(); stk_epc.delete();
        m_base = 0; m_vec = 32'h40; m_id = 0;
    endtask

    function automatic exp_t m_out();
        exp_t x;
        x.i  = |(m_pend & m_mask);
        x.n  = m_np;
        x.d  = stk_nmi.size() != 0;
        x.v  = m_vec;
        x.e  = stk_epc.size() != 0 ? stk_epc[stk_epc.size()-1] : m_base;
        x.id = m_id;
        return x;
    endfunction

    task automatic m_step();
        bit [3:0] rise, app, act;
        bit nrise, napp, int_ok, nmi_ok, er_ok;
        int sel;
        rise = irq & ~m_last; m_last = irq;
        app = m_d2; m_d2 = m_d1; m_d1 = rise;
        nrise = nmi & ~m_nlast; m_nlast = nmi;
        napp = m_nd2; m_nd2 = m_nd1; m_nd1 = nrise;
        act = m_pend & m_mask;
        int_ok = ack && ina && stk_nmi.size() == 0 && act != 0;
        nmi_ok = ack && !ina && m_np && (stk_nmi.size() == 0 || !stk_nmi[stk_nmi.size()-1]);
        er_ok  = eret && !ack && stk_nmi.size() != 0;
        if (int_ok) begin
            sel = -1;
            for (int i = 0; i < 4; i++) if (act[i] && sel < 0) sel = i;
            m_pend[sel] = 0;
            m_id = 3'(sel);
            m_vec = 32'h80 + 32'(8 * sel);
            m_base = pc;
            stk_nmi.push_back(0); stk_epc.push_back(pc);
        end
        if (nmi_ok) begin
            m_np = 0;
            m_vec = 32'h40;
            if (stk_nmi.size() == 0) m_base = pc;
            stk_nmi.push_back(1); stk_epc.push_back(pc);
        end
        if (er_ok) begin
            void'(stk_nmi.pop_back()); void'(stk_epc.pop_back());
        end
        m_pend |= app;
        m_np |= napp;
        if (mask_we) m_mask = mask_in;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_step();
        sb.push_back(m_out());
        #1;
        ack = 0; eret = 0; mask_we = 0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1 rst_n = 0;
        m_reset();
        sb.push_back(m_out());
        #1 smp = 1;
        #1 smp = 0;
        ticks(3);
        rst_n = 1;
    endtask

    always @(negedge clk or posedge smp) begin
        exp_t x, got;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            got = '{i: int_o, n: nmi_o, d: intd_o, v: vector_o, e: epc_o, id: irq_id_o};
            vectors++;
            if (got !== x) begin
                miscompares++;
                $display("FAIL outputs @%0t: got INT=%b NMI=%b INTD=%b Vector=%h Epc=%h IrqId=%0d, expected INT=%b NMI=%b INTD=%b Vector=%h Epc=%h IrqId=%0d",
                         $time, got.i, got.n, got.d, got.v, got.e, got.id, x.i, x.n, x.d, x.v, x.e, x.id);
            end
        end
    end

    initial begin
        m_reset();
        ticks(3);
        rst_n = 1;
        tick();
        // single masked-in line, ack and return
        mask_we = 1; mask_in = 4'b0100; irq[2] = 1;
        ticks(4);
        ack = 1; ina = 1; pc = 32'h100; tick();
        tick();
        eret = 1; tick();
        irq = 0; ticks(2);
        // two pending lines, priority to line 1
        mask_we = 1; mask_in = 4'b1010; irq[1] = 1; irq[3] = 1;
        ticks(4);
        ack = 1; ina = 1; pc = 32'h100; tick();
        tick();
        // NMI preempting the INT handler, then unwinding
        nmi = 1; ticks(4);
        ack = 1; ina = 0; pc = 32'h204; tick();
        tick();
        eret = 1; tick();
        eret = 1; tick();
        nmi = 0; irq = 0; ticks(2);
        // new edge on line 0 in the same cycle its pending bit is cleared
        mask_we = 1; mask_in = 4'b0001; irq[0] = 1;
        ticks(3);
        irq[0] = 0; tick();
        irq[0] = 1; ticks(2);
        ack = 1; ina = 1; pc = 32'h300; tick();
        tick();
        eret = 1; tick();
        // masked line latches, INT rises once enabled
        irq = 0; mask_we = 1; mask_in = 4'b0000; ticks(2);
        irq[3] = 1; ticks(4);
        mask_we = 1; mask_in = 4'b1000; tick();
        tick();
        // enter NMI_NEST, then async reset between edges
        ack = 1; ina = 1; pc = 32'h400; tick();
        nmi = 1; ticks(4);
        ack = 1; ina = 0; pc = 32'h404; tick();
        tick();
        async_reset();
        nmi = 0; irq = 0; ticks(2);
        // random traffic
        for (int c = 0; c < 400; c++) begin
            irq  = irq ^ (($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0);
            if ($urandom_range(0, 7) == 0) nmi = ~nmi;
            ack  = $urandom_range(0, 3) == 0;
            ina  = 1'($urandom);
            eret = $urandom_range(0, 5) == 0;
            mask_we = $urandom_range(0, 9) == 0;
            mask_in = 4'($urandom);
            pc = {$urandom} & 32'hFFFF_FFFC;
            tick();
        end
        ticks(2);
        @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
